// File: rtl/vga_sync_timer.sv
// VGA raster timing generator: hpos/vpos counters, display_on, hsync/vsync, line/frame strobes, frame counter.
// Latency: every output is a register loaded from the next counter state, so all outputs of a cycle agree with that cycle's hpos/vpos.
// Backpressure: none; pix_en=0 freezes the raster (counters and decodes hold, strobes drop to 0).
module vga_sync_timer #(
    parameter int H_DISPLAY       = 640,
    parameter int H_FRONT         = 16,
    parameter int H_SYNC          = 96,
    parameter int H_BACK          = 48,
    parameter int V_DISPLAY       = 480,
    parameter int V_FRONT         = 10,
    parameter int V_SYNC          = 2,
    parameter int V_BACK          = 33,
    parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    // Raster geometry. Both totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Terminal counts used for the wrap compares.
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode boundaries kept at 11 bits so a sync pulse ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END  = 11'(H_DISPLAY);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] H_SYNC_END = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_DISPLAY);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_DISPLAY + V_FRONT);
    localparam logic [10:0] V_SYNC_END = 11'(V_DISPLAY + V_FRONT + V_SYNC);

    // Level driven on the sync pins outside the pulse; XOR with "active" yields the pin level.
    localparam logic SYNC_IDLE = SYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic [7:0] fc_nxt;
    logic       h_wrap;
    logic       v_wrap;
    logic       hs_act;
    logic       vs_act;
    logic       vis;

    // Next raster position: step only on pix_en, wrapping line then frame.
    always_comb begin
        h_nxt  = hpos;
        v_nxt  = vpos;
        fc_nxt = frame_count;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (pix_en) begin
            if (hpos == H_LAST) begin
                h_nxt  = '0;
                h_wrap = 1'b1;
                if (vpos == V_LAST) begin
                    v_nxt  = '0;
                    v_wrap = 1'b1;
                    fc_nxt = frame_count + 8'd1;
                end else begin
                    v_nxt = vpos + 10'd1;
                end
            end else begin
                h_nxt = hpos + 10'd1;
            end
        end
    end

    // Decode the next position so the registered outputs line up with the registered counters.
    always_comb begin
        hs_act = ({1'b0, h_nxt} >= H_SYNC_BEG) && ({1'b0, h_nxt} < H_SYNC_END);
        vs_act = ({1'b0, v_nxt} >= V_SYNC_BEG) && ({1'b0, v_nxt} < V_SYNC_END);
        vis    = ({1'b0, h_nxt} < H_VIS_END) && ({1'b0, v_nxt} < V_VIS_END);
    end

    // Output registers; reset wins over pix_en and never produces a strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            hpos        <= '0;
            vpos        <= '0;
            display_on  <= 1'b1;
            hsync       <= SYNC_IDLE;
            vsync       <= SYNC_IDLE;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            hpos        <= h_nxt;
            vpos        <= v_nxt;
            display_on  <= vis;
            hsync       <= hs_act ^ SYNC_IDLE;
            vsync       <= vs_act ^ SYNC_IDLE;
            // v_wrap is only ever set alongside h_wrap, so frame_start implies line_start.
            line_start  <= h_wrap;
            frame_start <= v_wrap;
            frame_count <= fc_nxt;
        end
    end

endmodule

// File: tb/tb_vga_sync_timer.sv
// Directed bench: full-size 640x480 timing for line-level behaviour, plus a small
// 16x10 raster (active-high sync) so whole frames and the frame counter wrap stay short.
module tb_vga_sync_timer;

    logic       clk;
    logic       d_reset, d_pix_en;
    logic [9:0] d_hpos, d_vpos;
    logic       d_display_on, d_hsync, d_vsync, d_line_start, d_frame_start;
    logic [7:0] d_frame_count;

    logic       s_reset, s_pix_en;
    logic [9:0] s_hpos, s_vpos;
    logic       s_display_on, s_hsync, s_vsync, s_line_start, s_frame_start;
    logic [7:0] s_frame_count;

    int n_cmp = 0;
    int n_err = 0;

    vga_sync_timer u_dut (
        .clk(clk), .reset(d_reset), .pix_en(d_pix_en),
        .hpos(d_hpos), .vpos(d_vpos), .display_on(d_display_on),
        .hsync(d_hsync), .vsync(d_vsync), .line_start(d_line_start),
        .frame_start(d_frame_start), .frame_count(d_frame_count)
    );

    // Small raster: H 8+2+3+3 = 16 (hsync 10..12), V 6+1+2+1 = 10 (vsync 7..8), frame = 160 clks.
    vga_sync_timer #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE_LOW(1'b0)
    ) u_small (
        .clk(clk), .reset(s_reset), .pix_en(s_pix_en),
        .hpos(s_hpos), .vpos(s_vpos), .display_on(s_display_on),
        .hsync(s_hsync), .vsync(s_vsync), .line_start(s_line_start),
        .frame_start(s_frame_start), .frame_count(s_frame_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ls_cnt, fs_cnt, disp_cnt, hs_cnt, vs_cnt;
        int h, v;

        // ---------------- reset both instances ----------------
        d_reset = 1'b1; d_pix_en = 1'b0;
        s_reset = 1'b1; s_pix_en = 1'b0;
        tick();
        check("d_rst_hpos", 32'(d_hpos), 0);
        check("d_rst_vpos", 32'(d_vpos), 0);
        check("d_rst_disp", 32'(d_display_on), 1);
        check("d_rst_hsync", 32'(d_hsync), 1);
        check("d_rst_vsync", 32'(d_vsync), 1);
        check("d_rst_ls", 32'(d_line_start), 0);
        check("d_rst_fs", 32'(d_frame_start), 0);
        check("d_rst_fc", 32'(d_frame_count), 0);
        check("s_rst_hsync", 32'(s_hsync), 0);
        check("s_rst_vsync", 32'(s_vsync), 0);
        check("s_rst_disp", 32'(s_display_on), 1);

        // ---------------- full-size: first line ----------------
        d_reset = 1'b0; d_pix_en = 1'b1;
        s_reset = 1'b0;
        for (int k = 1; k < 800; k++) begin
            tick();
            check("d_line_hpos", 32'(d_hpos), k);
            check("d_line_vpos", 32'(d_vpos), 0);
            check("d_line_ls", 32'(d_line_start), 0);
            check("d_line_fs", 32'(d_frame_start), 0);
            check("d_line_disp", 32'(d_display_on), (k < 640) ? 1 : 0);
            check("d_line_hsync", 32'(d_hsync), (k >= 656 && k < 752) ? 0 : 1);
            check("d_line_vsync", 32'(d_vsync), 1);
        end
        tick();  // clk 800: wrap into line 1
        check("d_wrap_hpos", 32'(d_hpos), 0);
        check("d_wrap_vpos", 32'(d_vpos), 1);
        check("d_wrap_ls", 32'(d_line_start), 1);
        check("d_wrap_fs", 32'(d_frame_start), 0);
        check("d_wrap_disp", 32'(d_display_on), 1);
        check("d_wrap_fc", 32'(d_frame_count), 0);
        tick();
        check("d_801_hpos", 32'(d_hpos), 1);
        check("d_801_ls", 32'(d_line_start), 0);
        check("s_idle_hpos", 32'(s_hpos), 0);
        check("s_idle_ls", 32'(s_line_start), 0);

        // ---------------- full-size: pix_en 1,0,1,0 at wrap ----------------
        repeat (798) tick();
        check("d_end1_hpos", 32'(d_hpos), 799);
        check("d_end1_vpos", 32'(d_vpos), 1);
        d_pix_en = 1'b1; tick();
        check("d_tg1_hpos", 32'(d_hpos), 0);
        check("d_tg1_vpos", 32'(d_vpos), 2);
        check("d_tg1_ls", 32'(d_line_start), 1);
        d_pix_en = 1'b0; tick();
        check("d_tg0_hpos", 32'(d_hpos), 0);
        check("d_tg0_vpos", 32'(d_vpos), 2);
        check("d_tg0_ls", 32'(d_line_start), 0);
        check("d_tg0_disp", 32'(d_display_on), 1);
        check("d_tg0_hsync", 32'(d_hsync), 1);
        d_pix_en = 1'b1; tick();
        check("d_tg2_hpos", 32'(d_hpos), 1);
        check("d_tg2_ls", 32'(d_line_start), 0);
        d_pix_en = 1'b0; tick();
        check("d_tg3_hpos", 32'(d_hpos), 1);
        check("d_tg3_ls", 32'(d_line_start), 0);

        // ---------------- small raster: one full frame ----------------
        s_pix_en = 1'b1;
        ls_cnt = 0; fs_cnt = 0; disp_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int k = 1; k <= 160; k++) begin
            tick();
            h = k % 16;
            v = (k / 16) % 10;
            check("s_fr_hpos", 32'(s_hpos), h);
            check("s_fr_vpos", 32'(s_vpos), v);
            check("s_fr_hsync", 32'(s_hsync), (h >= 10 && h < 13) ? 1 : 0);
            check("s_fr_vsync", 32'(s_vsync), (v >= 7 && v < 9) ? 1 : 0);
            check("s_fr_disp", 32'(s_display_on), (h < 8 && v < 6) ? 1 : 0);
            check("s_fr_ls", 32'(s_line_start), (h == 0) ? 1 : 0);
            check("s_fr_fc", 32'(s_frame_count), k / 160);
            if (s_line_start) ls_cnt++;
            if (s_frame_start) begin
                fs_cnt++;
                check("s_fs_ls", 32'(s_line_start), 1);
                check("s_fs_fc", 32'(s_frame_count), 1);
                check("s_fs_hpos", 32'(s_hpos), 0);
                check("s_fs_vpos", 32'(s_vpos), 0);
            end
            if (s_display_on) disp_cnt++;
            if (s_hsync) hs_cnt++;
            if (s_vsync) vs_cnt++;
        end
        check("s_cnt_ls", ls_cnt, 10);
        check("s_cnt_fs", fs_cnt, 1);
        check("s_cnt_disp", disp_cnt, 48);
        check("s_cnt_hsync", hs_cnt, 30);
        check("s_cnt_vsync", vs_cnt, 32);

        // ---------------- small raster: reset mid-frame ----------------
        repeat (640 + 67) tick();
        check("s_pre_hpos", 32'(s_hpos), 3);
        check("s_pre_vpos", 32'(s_vpos), 4);
        check("s_pre_fc", 32'(s_frame_count), 5);
        s_reset = 1'b1; s_pix_en = 1'b0; tick();
        check("s_mr_hpos", 32'(s_hpos), 0);
        check("s_mr_vpos", 32'(s_vpos), 0);
        check("s_mr_fc", 32'(s_frame_count), 0);
        check("s_mr_hsync", 32'(s_hsync), 0);
        check("s_mr_vsync", 32'(s_vsync), 0);
        check("s_mr_fs", 32'(s_frame_start), 0);
        check("s_mr_ls", 32'(s_line_start), 0);
        check("s_mr_disp", 32'(s_display_on), 1);
        s_reset = 1'b0; s_pix_en = 1'b1; tick();
        check("s_resume_hpos", 32'(s_hpos), 1);
        check("s_resume_vpos", 32'(s_vpos), 0);
        check("s_resume_ls", 32'(s_line_start), 0);

        // ---------------- small raster: 256 frames, counter wrap ----------------
        fs_cnt = 0;
        for (int k = 2; k <= 256 * 160; k++) begin
            tick();
            if (s_frame_start) fs_cnt++;
            if (k == 255 * 160) begin
                check("s_f255_fs", 32'(s_frame_start), 1);
                check("s_f255_fc", 32'(s_frame_count), 255);
            end
            if (k == 256 * 160) begin
                check("s_f256_fs", 32'(s_frame_start), 1);
                check("s_f256_ls", 32'(s_line_start), 1);
                check("s_f256_fc", 32'(s_frame_count), 0);
                check("s_f256_hpos", 32'(s_hpos), 0);
                check("s_f256_vpos", 32'(s_vpos), 0);
            end
        end
        check("s_cnt_fs256", fs_cnt, 256);
        tick();
        check("s_post_fs", 32'(s_frame_start), 0);
        check("s_post_fc", 32'(s_frame_count), 0);
        check("s_post_hpos", 32'(s_hpos), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_sync_timer.md
Name: vga_sync_timer

Overview:
- VGA raster timing generator. It is the front stage of every display pipeline in this design and feeds the pixel/logo renderer: hpos/vpos, display_on, hsync/vsync.
- Adds single-cycle line_start and frame_start strobes and a frame counter, so downstream animation logic needs no edge detection on vpos.
- Adds a pixel-enable input so the timing can run from a faster system clock.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync are driven low during the sync pulse

Ports:
- clk  input  1  pixel/system clock
- reset  input  1  synchronous, active-high reset
- pix_en  input  1  advance enable; counters step only on cycles with pix_en=1 (tie to 1 for a 25.175 MHz clk)
- hpos  output  10  current horizontal position, 0..H_TOTAL-1
- vpos  output  10  current vertical position, 0..V_TOTAL-1
- display_on  output  1  high when hpos<H_DISPLAY and vpos<V_DISPLAY
- hsync  output  1  horizontal sync, polarity per SYNC_ACTIVE_LOW
- vsync  output  1  vertical sync, polarity per SYNC_ACTIVE_LOW
- line_start  output  1  one-clk strobe on entering hpos=0
- frame_start  output  1  one-clk strobe on entering hpos=0, vpos=0
- frame_count  output  8  frames completed since reset, wraps 255->0

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- All outputs are registers. Every output in a given cycle is consistent with that cycle's hpos/vpos; there is no skew between counters and the decoded signals.
- Reset: on a clk edge with reset=1, set:
  - hpos=0, vpos=0, display_on=1
  - hsync, vsync at their inactive level (1 when SYNC_ACTIVE_LOW=1)
  - line_start=0, frame_start=0, frame_count=0
- Reset asserted mid-frame takes effect on the next edge regardless of pix_en. No strobe is generated by the reset itself.
- Advance on an edge with reset=0 and pix_en=1:
  - If hpos==H_TOTAL-1: hpos<=0.
    - If vpos==V_TOTAL-1: vpos<=0 and frame_count<=frame_count+1 (mod 256).
    - Otherwise: vpos<=vpos+1.
  - Otherwise: hpos<=hpos+1.
- Hold on an edge with pix_en=0: hpos, vpos, display_on, hsync, vsync and frame_count hold their values.
- Decode, registered from the next counter values:
  - hsync active iff H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751).
  - vsync active iff V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491).
  - vsync depends on vpos only, so it changes exactly when vpos changes (at hpos=0).
- Strobes:
  - line_start=1 only in the clk cycle immediately after an advance that wrapped hpos to 0. It is 0 in all other cycles, including later pix_en=0 hold cycles at hpos=0.
  - frame_start is the same, with the additional condition vpos=0.
  - frame_start=1 implies line_start=1 in the same cycle.
  - frame_count has already incremented in the cycle where frame_start=1.
- Width rule: H_TOTAL and V_TOTAL must be <=1024. Counters are 10 bits and never exceed TOTAL-1.
- Out-of-range states do not occur (counters compare with ==TOTAL-1 and are reset-initialised). No recovery logic is required.

Test Plan:
- Reset then pix_en=1 for 800 clks -> hpos steps 0..799 then 0. vpos 0->1 at clk 800. line_start high exactly in cycle 800. frame_start never high.
- Run 420000 clks (one full frame) -> frame_start high once, in the cycle where hpos=0 and vpos=0. frame_count=1 in that cycle. 525 line_start pulses total.
- Sample every cycle of a frame -> hsync low exactly for hpos 656..751. vsync low exactly for vpos 490..491. display_on high exactly for 640x480 = 307200 cycles per frame.
- pix_en toggled 1,0,1,0 at the wrap from hpos 799 -> hpos held during the 0 cycles. line_start high for exactly one clk, not stretched by the hold.
- Assert reset for 1 clk at hpos=300, vpos=200, frame_count=5 -> next cycle: hpos=0, vpos=0, frame_count=0, hsync=vsync=1, frame_start=0. Counting resumes normally afterwards.
- Run 256 frames with SYNC_ACTIVE_LOW=0 -> frame_count wraps 255->0. Sync pulses are active-high over the same hpos/vpos ranges.
